// File: rtl/sdram_bridge_pkg.sv
// Shared types and helpers for the byte-stream <-> SDRAM burst bridge.
package sdram_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_START,
    ST_WR_BURST,
    ST_RD_START,
    ST_RD_BURST
  } state_e;

  function automatic int unsigned bpw(input int unsigned data_w);
    return data_w / 8;
  endfunction

  function automatic int unsigned bursts_max(input int unsigned region_words,
                                             input int unsigned burst_len);
    return region_words / burst_len;
  endfunction

  // Advance a word pointer inside [base, base+region); region is a power of 2.
  function automatic logic [31:0] ptr_advance(input logic [31:0] ptr,
                                              input logic [31:0] base,
                                              input logic [31:0] step,
                                              input logic [31:0] region);
    logic [31:0] off;
    off = (ptr - base + step) & (region - 32'd1);
    return base + off;
  endfunction

endpackage

// File: rtl/burst_word_buf.sv
// BURST_LEN-deep word register file with independent write/read indices.
module burst_word_buf #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 16
) (
  input  logic                       sclk,
  input  logic                       srst_n,
  input  logic                       clr,
  input  logic                       wr_en,
  input  logic [DATA_W-1:0]          wr_word,
  input  logic                       rd_adv,
  output logic [DATA_W-1:0]          rd_word,
  output logic [$clog2(DEPTH+1)-1:0] wr_idx,
  output logic [$clog2(DEPTH+1)-1:0] rd_idx,
  output logic                       full,
  output logic                       empty
);
  localparam int IW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];

  assign full    = (wr_idx == IW'(DEPTH));
  assign empty   = (rd_idx == wr_idx);
  assign rd_word = mem[rd_idx[AW-1:0]];

  // clr only rewinds the indices; stale contents are never visible past wr_idx.
  always_ff @(posedge sclk or negedge srst_n) begin
    if (!srst_n) begin
      wr_idx <= '0;
      rd_idx <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clr) begin
      wr_idx <= '0;
      rd_idx <= '0;
    end else begin
      if (wr_en && !full) begin
        mem[wr_idx[AW-1:0]] <= wr_word;
        wr_idx              <= wr_idx + IW'(1);
      end
      if (rd_adv && !empty) rd_idx <= rd_idx + IW'(1);
    end
  end

endmodule

// File: rtl/sdram_stream_bridge.sv
// Packs a byte stream into SDRAM write bursts and unpacks read bursts back into
// bytes, treating a circular SDRAM region as a large FIFO.
module sdram_stream_bridge
  import sdram_bridge_pkg::*;
#(
  parameter int          DATA_W       = 16,
  parameter int          BURST_LEN    = 4,
  parameter int          ADDR_W       = 21,
  parameter int unsigned BASE_ADDR    = 0,
  parameter int          REGION_WORDS = 2048
) (
  input  logic              sclk,
  input  logic              srst_n,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  input  logic              rd_req,
  output logic              rd_drop,
  output logic              out_valid,
  output logic [7:0]        out_data,
  input  logic              out_ready,
  output logic              wr_trig,
  output logic [8:0]        wr_len,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  input  logic              wr_data_en,
  output logic              rd_trig,
  output logic [8:0]        rd_len,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  input  logic              rd_data_en,
  output logic              busy
);
  localparam int BPW  = bpw(DATA_W);
  localparam int BMAX = bursts_max(REGION_WORDS, BURST_LEN);
  localparam int BW   = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int SW   = $clog2(BMAX + 1);
  localparam int IW   = $clog2(BURST_LEN + 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [SW-1:0]     stored;
  logic              rd_pend;
  logic [BW-1:0]     byte_cnt, rbyte;
  logic [DATA_W-1:0] pack_q, pack_next;

  logic              wb_full, wb_empty, rb_full, rb_empty;
  logic [IW-1:0]     wb_widx, wb_ridx, rb_widx, rb_ridx;
  logic [DATA_W-1:0] wb_word, rb_word;

  logic in_fire, byte_last, word_done;
  logic wr_beat, wr_last, rd_beat, rd_last;
  logic out_fire, rbyte_last, rb_adv, rb_clr, can_read;
  logic unused_flags;

  assign in_ready   = !wb_full && (stored < SW'(BMAX));
  assign in_fire    = in_valid && in_ready;
  assign byte_last  = (byte_cnt == BW'(BPW - 1));
  assign word_done  = in_fire && byte_last;

  assign wr_beat    = (state_q == ST_WR_BURST) && wr_data_en;
  assign wr_last    = wr_beat && (wb_ridx == IW'(BURST_LEN - 1));
  assign rd_beat    = (state_q == ST_RD_BURST) && rd_data_en;
  assign rd_last    = rd_beat && (rb_widx == IW'(BURST_LEN - 1));

  assign out_valid  = !rb_empty;
  assign out_data   = rb_word[{rbyte, 3'b000} +: 8];
  assign out_fire   = out_valid && out_ready;
  assign rbyte_last = (rbyte == BW'(BPW - 1));
  assign rb_adv     = out_fire && rbyte_last;
  assign rb_clr     = rb_adv && (rb_ridx == IW'(BURST_LEN - 1));

  // A burst committing this cycle makes data available to a same-cycle rd_req.
  assign can_read   = (stored != '0) || wr_last;

  assign wr_trig    = (state_q == ST_WR_START);
  assign rd_trig    = (state_q == ST_RD_START);
  assign busy       = (state_q != ST_IDLE);
  assign wr_len     = 9'(BURST_LEN);
  assign rd_len     = 9'(BURST_LEN);
  assign wr_addr    = wr_ptr;
  assign rd_addr    = rd_ptr;
  assign wr_data    = wb_word;

  assign unused_flags = ^{wb_empty, rb_full, wb_widx};

  // Little-endian packing: byte k of a word lands in bits [8k+7:8k].
  always_comb begin
    pack_next = pack_q;
    pack_next[{byte_cnt, 3'b000} +: 8] = in_data;
  end

  burst_word_buf #(.DEPTH(BURST_LEN), .DATA_W(DATA_W)) u_wbuf (
    .sclk    (sclk),
    .srst_n  (srst_n),
    .clr     (wr_last),
    .wr_en   (word_done),
    .wr_word (pack_next),
    .rd_adv  (wr_beat),
    .rd_word (wb_word),
    .wr_idx  (wb_widx),
    .rd_idx  (wb_ridx),
    .full    (wb_full),
    .empty   (wb_empty)
  );

  burst_word_buf #(.DEPTH(BURST_LEN), .DATA_W(DATA_W)) u_rbuf (
    .sclk    (sclk),
    .srst_n  (srst_n),
    .clr     (rb_clr),
    .wr_en   (rd_beat),
    .wr_word (rd_data),
    .rd_adv  (rb_adv),
    .rd_word (rb_word),
    .wr_idx  (rb_widx),
    .rd_idx  (rb_ridx),
    .full    (rb_full),
    .empty   (rb_empty)
  );

  // Writes take priority so a full wbuf never stalls the input behind a read.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (wb_full)                 state_d = ST_WR_START;
        else if (rd_pend && rb_empty) state_d = ST_RD_START;
      end
      ST_WR_START: state_d = ST_WR_BURST;
      ST_WR_BURST: if (wr_last) state_d = ST_IDLE;
      ST_RD_START: state_d = ST_RD_BURST;
      ST_RD_BURST: if (rd_last) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sclk or negedge srst_n) begin
    if (!srst_n) begin
      state_q  <= ST_IDLE;
      wr_ptr   <= ADDR_W'(BASE_ADDR);
      rd_ptr   <= ADDR_W'(BASE_ADDR);
      stored   <= '0;
      rd_pend  <= 1'b0;
      rd_drop  <= 1'b0;
      byte_cnt <= '0;
      rbyte    <= '0;
      pack_q   <= '0;
    end else begin
      state_q <= state_d;
      rd_drop <= rd_req && !can_read;
      if (rd_last)                  rd_pend <= 1'b0;
      else if (rd_req && can_read)  rd_pend <= 1'b1;
      if (wr_last) begin
        stored <= stored + SW'(1);
        wr_ptr <= ADDR_W'(ptr_advance(32'(wr_ptr), 32'(BASE_ADDR),
                                      32'(BURST_LEN), 32'(REGION_WORDS)));
      end else if (rd_last) begin
        stored <= stored - SW'(1);
        rd_ptr <= ADDR_W'(ptr_advance(32'(rd_ptr), 32'(BASE_ADDR),
                                      32'(BURST_LEN), 32'(REGION_WORDS)));
      end
      if (in_fire) begin
        pack_q   <= pack_next;
        byte_cnt <= byte_last ? '0 : byte_cnt + BW'(1);
      end
      if (out_fire) rbyte <= rbyte_last ? '0 : rbyte + BW'(1);
    end
  end

endmodule

// File: tb/tb_sdram_stream_bridge.sv
// Scoreboard bench: byte-FIFO reference model, SDRAM responder and output monitor.
module tb_sdram_stream_bridge;
  localparam int DATA_W = 16, BURST_LEN = 4, ADDR_W = 21, REGION = 8;
  localparam int BPW = DATA_W / 8, BB = BURST_LEN * BPW, BMAX = REGION / BURST_LEN;

  logic              sclk = 1'b0, srst_n = 1'b0;
  logic              in_valid = 1'b0, rd_req = 1'b0, out_ready = 1'b0;
  logic [7:0]        in_data = '0;
  logic              wr_data_en = 1'b0, rd_data_en = 1'b0;
  logic [DATA_W-1:0] rd_data = '0;
  logic              in_ready, rd_drop, out_valid, wr_trig, rd_trig, busy;
  logic [7:0]        out_data;
  logic [8:0]        wr_len, rd_len;
  logic [ADDR_W-1:0] wr_addr, rd_addr;
  logic [DATA_W-1:0] wr_data;

  always #5 sclk = ~sclk;

  sdram_stream_bridge #(.DATA_W(DATA_W), .BURST_LEN(BURST_LEN), .ADDR_W(ADDR_W),
                        .BASE_ADDR(0), .REGION_WORDS(REGION)) dut (
    .sclk(sclk), .srst_n(srst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .rd_req(rd_req), .rd_drop(rd_drop), .out_valid(out_valid),
    .out_data(out_data), .out_ready(out_ready), .wr_trig(wr_trig), .wr_len(wr_len),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_data_en(wr_data_en), .rd_trig(rd_trig),
    .rd_len(rd_len), .rd_addr(rd_addr), .rd_data(rd_data), .rd_data_en(rd_data_en),
    .busy(busy)
  );

  typedef struct { bit drop; int addr; } rd_exp_t;

  int          n_cmp = 0, n_bad = 0;
  rd_exp_t     exp_rd[$];
  int          exp_waddr[$];
  logic [15:0] exp_wword[$];
  logic [7:0]  exp_out[$], ref_bytes[$], pb[$];
  logic [15:0] mem [REGION];
  int          bursts_wr = 0, reads_ok = 0, sent = 0;
  int          abort_after = -1;
  bit          aborted = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic miss(input string name);
    n_cmp++; n_bad++;
    $display("FAIL %s: unexpected or missing event", name);
  endtask

  // Reference model: a byte FIFO; every BB bytes form one burst in region order.
  task automatic model_push(input logic [7:0] b);
    ref_bytes.push_back(b);
    pb.push_back(b);
    sent++;
    if (pb.size() == BB) begin
      for (int i = 0; i < BURST_LEN; i++) exp_wword.push_back({pb[2*i+1], pb[2*i]});
      exp_waddr.push_back((bursts_wr * BURST_LEN) % REGION);
      bursts_wr++;
      pb.delete();
    end
  endtask

  function automatic int stored_m();
    return bursts_wr - reads_ok;
  endfunction

  task automatic expect_read();
    if (stored_m() == 0) exp_rd.push_back('{drop: 1'b1, addr: 0});
    else begin
      exp_rd.push_back('{drop: 1'b0, addr: (reads_ok * BURST_LEN) % REGION});
      for (int i = 0; i < BB; i++) exp_out.push_back(ref_bytes.pop_front());
      reads_ok++;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    in_valid = 1'b1; in_data = b;
    while (!in_ready && n < 2000) begin @(negedge sclk); n++; end
    if (!in_ready) begin miss("in_ready timeout"); in_valid = 1'b0; return; end
    model_push(b);
    @(negedge sclk);
    in_valid = 1'b0;
    if ($urandom_range(0, 3) == 0) @(negedge sclk);
  endtask

  task automatic send_rand(input int k);
    for (int i = 0; i < k; i++) send_byte(8'($urandom_range(0, 255)));
  endtask

  task automatic do_rd_req(input bit dbl);
    expect_read();
    rd_req = 1'b1; @(negedge sclk); rd_req = 1'b0;
    if (dbl) begin @(negedge sclk); rd_req = 1'b1; @(negedge sclk); rd_req = 1'b0; end
  endtask

  task automatic quiesce();
    int n = 0;
    repeat (4) @(negedge sclk);
    while ((busy || exp_out.size() != 0 || exp_waddr.size() != 0 || exp_rd.size() != 0
            || exp_wword.size() != 0) && n < 5000) begin
      @(negedge sclk); n++;
    end
    if (n >= 5000) miss("quiesce timeout");
    check("in_ready vs region fill", in_ready, stored_m() < BMAX);
  endtask

  // SDRAM controller stand-in: serves bursts with random beat gaps.
  task automatic sdram_write();
    int a;
    if (exp_waddr.size() == 0) begin miss("wr_trig unexpected"); a = int'(wr_addr); end
    else begin a = exp_waddr.pop_front(); check("wr_addr", wr_addr, a); end
    check("wr_len", wr_len, BURST_LEN);
    for (int i = 0; i < BURST_LEN; i++) begin
      @(negedge sclk); wr_data_en = 1'b0;
      while ($urandom_range(0, 2) == 0) @(negedge sclk);
      if (i == abort_after) begin aborted = 1'b1; return; end
      wr_data_en = 1'b1;
      if (exp_wword.size() == 0) miss("wr_data extra");
      else check("wr_data", wr_data, exp_wword.pop_front());
      check("wr_addr stable", wr_addr, a);
      mem[(a + i) % REGION] = wr_data;
    end
  endtask

  task automatic sdram_read();
    int a;
    rd_exp_t e;
    check("rd_len", rd_len, BURST_LEN);
    if (exp_rd.size() == 0) begin miss("rd_trig unexpected"); a = int'(rd_addr); end
    else begin
      e = exp_rd.pop_front();
      check("rd_trig kind", 1'b0, e.drop);
      check("rd_addr", rd_addr, e.addr);
      a = e.addr;
    end
    for (int i = 0; i < BURST_LEN; i++) begin
      @(negedge sclk); rd_data_en = 1'b0;
      while ($urandom_range(0, 2) == 0) @(negedge sclk);
      rd_data_en = 1'b1;
      rd_data = mem[(a + i) % REGION];
    end
  endtask

  initial begin : sdram_model
    for (int i = 0; i < REGION; i++) mem[i] = '0;
    forever begin
      @(negedge sclk);
      wr_data_en = 1'b0; rd_data_en = 1'b0;
      if (srst_n) begin
        if (wr_trig)      sdram_write();
        else if (rd_trig) sdram_read();
      end
    end
  end

  initial begin : out_mon
    forever begin
      @(negedge sclk);
      out_ready = ($urandom_range(0, 3) != 0);
      if (srst_n && out_valid && out_ready) begin
        if (exp_out.size() == 0) miss("out byte unexpected");
        else check("out_data", out_data, exp_out.pop_front());
      end
    end
  end

  initial begin : drop_mon
    rd_exp_t e;
    forever begin
      @(negedge sclk);
      if (srst_n && rd_drop) begin
        if (exp_rd.size() == 0) miss("rd_drop unexpected");
        else begin e = exp_rd.pop_front(); check("rd_drop kind", 1'b1, e.drop); end
      end
    end
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    logic [7:0] b;
    int n, need;
    repeat (3) @(negedge sclk);
    srst_n = 1'b1;
    @(negedge sclk);
    check("reset in_ready", in_ready, 1);
    check("reset busy", busy, 0);
    check("reset out_valid", out_valid, 0);
    check("reset wr_trig", wr_trig, 0);
    check("reset wr_addr", wr_addr, 0);
    check("reset rd_addr", rd_addr, 0);

    // rd_req with nothing stored is dropped
    do_rd_req(1'b0);
    quiesce();

    // 0x11..0x88 forms one burst at address 0; wr_trig 2 cycles after last byte
    for (int i = 1; i < 8; i++) send_byte(8'(i * 8'h11));
    in_valid = 1'b1; in_data = 8'h88; n = 0;
    while (!in_ready && n < 100) begin @(negedge sclk); n++; end
    model_push(8'h88);
    @(negedge sclk); in_valid = 1'b0;
    @(negedge sclk);
    check("wr_trig latency", wr_trig, 1);
    quiesce();
    do_rd_req(1'b0);
    quiesce();
    do_rd_req(1'b0);
    quiesce();

    // fill the region, then free one burst and watch the write pointer wrap
    send_rand(2 * BB);
    quiesce();
    do_rd_req(1'b0);
    quiesce();
    send_rand(BB);
    quiesce();
    do_rd_req(1'b1);
    quiesce();
    do_rd_req(1'b0);
    quiesce();

    // randomized mix of partial writes, reads and absorbed double requests
    for (int it = 0; it < 40; it++) begin
      need = 2 * BB - (sent - reads_ok * BB);
      if ($urandom_range(0, 1) == 0 && need > 0) send_rand($urandom_range(1, need));
      else do_rd_req(stored_m() > 0 && $urandom_range(0, 1) == 1);
      quiesce();
    end

    // wbuf filling and rd_pend setting on the same cycle: write goes first
    if (stored_m() == 0) begin send_rand(BB); quiesce(); end
    if (stored_m() == BMAX) begin do_rd_req(1'b0); quiesce(); end
    need = BB - pb.size();
    send_rand(need - 1);
    b = 8'($urandom_range(0, 255));
    in_valid = 1'b1; in_data = b; n = 0;
    while (!in_ready && n < 100) begin @(negedge sclk); n++; end
    expect_read();
    model_push(b);
    rd_req = 1'b1;
    @(negedge sclk); in_valid = 1'b0; rd_req = 1'b0;
    n = 0;
    while (!wr_trig && !rd_trig && n < 50) begin @(negedge sclk); n++; end
    check("first trig is write", wr_trig, 1);
    check("no read before write", rd_trig, 0);
    quiesce();

    // reset in the middle of a write burst
    if (stored_m() == BMAX) begin do_rd_req(1'b0); quiesce(); end
    abort_after = 2;
    send_rand(BB - pb.size());
    n = 0;
    while (!aborted && n < 200) begin @(negedge sclk); n++; end
    if (!aborted) miss("abort point not reached");
    check("busy mid-burst", busy, 1);
    srst_n = 1'b0;
    @(negedge sclk);
    check("rst busy", busy, 0);
    check("rst wr_trig", wr_trig, 0);
    check("rst wr_addr", wr_addr, 0);
    check("rst rd_addr", rd_addr, 0);
    check("rst wr_data", wr_data, 0);
    check("rst out_valid", out_valid, 0);
    check("rst rd_drop", rd_drop, 0);
    exp_rd.delete(); exp_waddr.delete(); exp_wword.delete(); exp_out.delete();
    ref_bytes.delete(); pb.delete();
    bursts_wr = 0; reads_ok = 0; sent = 0; abort_after = -1;
    @(negedge sclk);
    srst_n = 1'b1;
    @(negedge sclk);
    check("post-reset in_ready", in_ready, 1);
    send_rand(BB);
    quiesce();
    do_rd_req(1'b0);
    quiesce();
    do_rd_req(1'b0);
    quiesce();

    check("leftover expectations",
          exp_out.size() + exp_rd.size() + exp_waddr.size() + exp_wword.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
